// File: rtl/bus_cycle_sequencer_if.sv
// Handshake and status bundle between the 68k bus engine control and the bus-cycle sequencer.
// The sequencer uses the slave view; whoever requests transfers and watches status uses master.
interface bus_cycle_sequencer_if #(
    parameter int BEAT_W = 4
);
    logic              ACTIVATE;
    logic [BEAT_W-1:0] BURST_LEN;
    logic              AS_FEEDBACK;
    logic              LATCH;
    logic              BERR;
    logic              MC_CLK_RISING;
    logic [3:0]        STATE;
    logic              BUSY;
    logic [BEAT_W-1:0] BEAT;
    logic              DONE;
    logic              ERR;
    logic              TIMEOUT;

    modport slave (
        input  ACTIVATE, BURST_LEN, AS_FEEDBACK, LATCH, BERR, MC_CLK_RISING,
        output STATE, BUSY, BEAT, DONE, ERR, TIMEOUT
    );

    modport master (
        output ACTIVATE, BURST_LEN, AS_FEEDBACK, LATCH, BERR, MC_CLK_RISING,
        input  STATE, BUSY, BEAT, DONE, ERR, TIMEOUT
    );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// Bus-cycle state machine for the 68k bus engine: sequences burst beats with a programmable
// setup hold, AS/DSACK watchdog, and a recoverable ERROR state on BERR or timeout.
module bus_cycle_sequencer #(
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int BEAT_W         = 4,
    parameter int TMR_W          = 11
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    bus_cycle_sequencer_if.slave  bus
);

    typedef enum logic [3:0] {
        S_WAIT       = 4'd0,
        S_WAKEUP     = 4'd1,
        S_ACTIVATE   = 4'd2,
        S_SETUP_BUS  = 4'd3,
        S_DRIVE_AS   = 4'd4,
        S_DRIVE_DS   = 4'd5,
        S_WAIT_DSACK = 4'd6,
        S_LATCH      = 4'd7,
        S_CLEAR_AS   = 4'd8,
        S_ON_DSACK   = 4'd9,
        S_FINALIZE   = 4'd10,
        S_CONTINUE   = 4'd11,
        S_ERROR      = 4'd12
    } state_t;

    localparam bit               WDOG_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] WDOG_LAST  = WDOG_EN ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TMR_W-1:0] TMR_MAX    = '1;

    state_t            r_state;
    state_t            w_next;
    logic [TMR_W-1:0]  r_timer;
    logic [TMR_W-1:0]  w_timer_nxt;
    logic [BEAT_W-1:0] r_len;
    logic [BEAT_W-1:0] r_beat;
    logic              r_done;
    logic              r_err;
    logic              r_timeout;

    logic w_wdog;
    logic w_bus_released;
    logic w_accept;
    logic w_inc_beat;
    logic w_wdog_err;
    logic w_done_nxt;
    logic w_err_nxt;

    assign w_wdog         = WDOG_EN && (r_timer == WDOG_LAST);
    assign w_bus_released = !bus.AS_FEEDBACK && bus.MC_CLK_RISING;

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_inc_beat = 1'b0;
        w_wdog_err = 1'b0;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (bus.ACTIVATE) begin
                    w_next   = S_WAKEUP;
                    w_accept = 1'b1;
                end
            end
            S_WAKEUP:    w_next = S_ACTIVATE;
            S_ACTIVATE:  w_next = S_SETUP_BUS;
            S_SETUP_BUS: begin
                if (r_timer == SETUP_LAST) w_next = S_DRIVE_AS;
            end
            S_DRIVE_AS: begin
                if (bus.AS_FEEDBACK) begin
                    w_next = S_DRIVE_DS;
                end else if (w_wdog) begin
                    w_next     = S_ERROR;
                    w_wdog_err = 1'b1;
                end
            end
            S_DRIVE_DS:  w_next = S_WAIT_DSACK;
            // BERR outranks LATCH; LATCH outranks a simultaneous watchdog expiry
            S_WAIT_DSACK: begin
                if (bus.BERR) begin
                    w_next = S_ERROR;
                end else if (bus.LATCH) begin
                    w_next = S_LATCH;
                end else if (w_wdog) begin
                    w_next     = S_ERROR;
                    w_wdog_err = 1'b1;
                end
            end
            S_LATCH:     w_next = S_CLEAR_AS;
            S_CLEAR_AS:  w_next = S_ON_DSACK;
            S_ON_DSACK: begin
                if (w_bus_released) w_next = S_FINALIZE;
            end
            S_FINALIZE: begin
                if (r_beat != r_len) begin
                    w_next = S_CONTINUE;
                end else begin
                    w_next     = S_WAIT;
                    w_done_nxt = 1'b1;
                end
            end
            S_CONTINUE: begin
                w_next     = S_SETUP_BUS;
                w_inc_beat = 1'b1;
            end
            S_ERROR: begin
                if (w_bus_released) begin
                    w_next    = S_WAIT;
                    w_err_nxt = 1'b1;
                end
            end
            default:     w_next = S_WAIT;
        endcase
    end

    // Timer restarts on every state change and saturates while a state is held
    always_comb begin
        w_timer_nxt = r_timer;
        if (w_next != r_state) begin
            w_timer_nxt = '0;
        end else if (r_timer != TMR_MAX) begin
            w_timer_nxt = r_timer + TMR_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state   <= S_WAIT;
            r_timer   <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_len     <= bus.BURST_LEN;
                r_beat    <= '0;
                r_timeout <= 1'b0;
            end else begin
                if (w_inc_beat) r_beat <= r_beat + BEAT_W'(1);
                if (w_wdog_err) r_timeout <= 1'b1;
            end
        end
    end

    assign bus.STATE   = r_state;
    assign bus.BUSY    = (r_state != S_WAIT);
    assign bus.BEAT    = r_beat;
    assign bus.DONE    = r_done;
    assign bus.ERR     = r_err;
    assign bus.TIMEOUT = r_timeout;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer: instance A (setup 1, watchdog 16) and
// instance B (setup 2, watchdog disabled) driven by a small reactive bus model.
module tb_bus_cycle_sequencer;

    localparam int BW = 4;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic mc;

    bus_cycle_sequencer_if #(.BEAT_W(BW)) ifa ();
    bus_cycle_sequencer_if #(.BEAT_W(BW)) ifb ();

    bus_cycle_sequencer #(.SETUP_CYCLES(1), .TIMEOUT_CYCLES(16), .BEAT_W(BW), .TMR_W(11)) dut_a (
        .CLK    (clk),
        .nRESET (rst_a),
        .bus    (ifa)
    );

    bus_cycle_sequencer #(.SETUP_CYCLES(2), .TIMEOUT_CYCLES(0), .BEAT_W(BW), .TMR_W(11)) dut_b (
        .CLK    (clk),
        .nRESET (rst_b),
        .bus    (ifb)
    );

    logic          act_v   [2];
    logic [BW-1:0] len_v   [2];
    logic          as_v    [2];
    logic          latch_v [2];
    logic          berr_v  [2];

    logic [3:0]    st [2];
    logic [BW-1:0] bt [2];
    logic          dn [2];
    logic          er [2];
    logic          to [2];
    logic          by [2];

    assign ifa.ACTIVATE      = act_v[0];
    assign ifa.BURST_LEN     = len_v[0];
    assign ifa.AS_FEEDBACK   = as_v[0];
    assign ifa.LATCH         = latch_v[0];
    assign ifa.BERR          = berr_v[0];
    assign ifa.MC_CLK_RISING = mc;
    assign ifb.ACTIVATE      = act_v[1];
    assign ifb.BURST_LEN     = len_v[1];
    assign ifb.AS_FEEDBACK   = as_v[1];
    assign ifb.LATCH         = latch_v[1];
    assign ifb.BERR          = berr_v[1];
    assign ifb.MC_CLK_RISING = mc;

    assign st[0] = ifa.STATE;   assign st[1] = ifb.STATE;
    assign bt[0] = ifa.BEAT;    assign bt[1] = ifb.BEAT;
    assign dn[0] = ifa.DONE;    assign dn[1] = ifb.DONE;
    assign er[0] = ifa.ERR;     assign er[1] = ifb.ERR;
    assign to[0] = ifa.TIMEOUT; assign to[1] = ifb.TIMEOUT;
    assign by[0] = ifa.BUSY;    assign by[1] = ifb.BUSY;

    int n_checks;
    int n_fail;
    int cyc;
    int mc_cnt;

    int trace[$];
    int beats_at_as[$];
    int latch_cnt, done_cnt, err_cnt, last_s;
    int dsack_cnt, max_dwell;
    int t_start, t_das, t_dsack, t_err;
    int latch_delay   [2];
    int no_latch_beat [2];
    int berr_beat     [2];
    bit spam          [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 68k clock rising strobe: one cycle in four
    initial begin
        mc     = 1'b0;
        mc_cnt = 0;
        forever begin
            @(negedge clk);
            mc_cnt++;
            mc = (mc_cnt % 4 == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_trk();
        trace.delete();
        beats_at_as.delete();
        latch_cnt = 0; done_cnt = 0; err_cnt = 0;
        dsack_cnt = 0; max_dwell = 0;
        t_das = -1; t_dsack = -1; t_err = -1;
    endtask

    task automatic step(input int sel);
        int s;
        @(posedge clk);
        #1;
        cyc++;
        s = int'(st[sel]);
        if (dn[sel] === 1'b1) done_cnt++;
        if (er[sel] === 1'b1) err_cnt++;
        if (s != last_s) begin
            trace.push_back(s);
            if (s == 4) begin
                beats_at_as.push_back(int'(bt[sel]));
                if (t_das < 0) t_das = cyc;
            end
            if (s == 6) begin
                dsack_cnt = 0;
                t_dsack   = cyc;
            end
            if (s == 7) latch_cnt++;
            if (s == 12) t_err = cyc;
            last_s = s;
        end else if (s == 6) begin
            dsack_cnt++;
        end
        if (s == 6 && dsack_cnt > max_dwell) max_dwell = dsack_cnt;
        as_v[sel]    = (s >= 4 && s <= 7);
        latch_v[sel] = (s == 6) && (latch_delay[sel] >= 0) && (dsack_cnt >= latch_delay[sel])
                       && (int'(bt[sel]) < no_latch_beat[sel]);
        berr_v[sel]  = (s == 6) && (int'(bt[sel]) == berr_beat[sel]);
        act_v[sel]   = spam[sel] && (s != 0);
    endtask

    task automatic run(input int sel, input int len, input int budget, input string tag);
        clear_trk();
        last_s     = int'(st[sel]);
        t_start    = cyc;
        len_v[sel] = BW'(len);
        act_v[sel] = 1'b1;
        step(sel);
        for (int i = 0; i < budget && last_s != 0; i++) step(sel);
        check({tag, "_back_to_wait"}, last_s, 0);
    endtask

    task automatic check_walk(input string tag);
        int n;
        check({tag, "_walk_len"}, trace.size(), 11);
        n = (trace.size() < 11) ? trace.size() : 11;
        for (int i = 0; i < n; i++)
            check($sformatf("%s_walk%0d", tag, i), trace[i], (i == 10) ? 0 : i + 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int k = 0; k < 2; k++) begin
            act_v[k] = 1'b0; len_v[k] = '0; as_v[k] = 1'b0; latch_v[k] = 1'b0; berr_v[k] = 1'b0;
            latch_delay[k] = 0; no_latch_beat[k] = 99; berr_beat[k] = -1; spam[k] = 1'b0;
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", st[0], 0);
        check("rst_beat", bt[0], 0);
        check("rst_done", dn[0], 0);
        check("rst_err", er[0], 0);
        check("rst_timeout", to[0], 0);
        check("rst_busy", by[0], 0);
        check("rst_state_b", st[1], 0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) step(0);

        // Single beat, everything answered on first sample
        run(0, 0, 100, "single");
        check_walk("single");
        check("single_done", done_cnt, 1);
        check("single_err", err_cnt, 0);
        check("single_beat", bt[0], 0);
        check("single_das_latency", t_das - t_start, 4);
        repeat (4) step(0);
        check("single_no_second_done", done_cnt, 1);

        // DSACK never arrives: watchdog after 16 cycles in WAIT_DSACK
        latch_delay[0] = -1;
        run(0, 0, 200, "wdog");
        check("wdog_dwell", t_err - t_dsack, 16);
        check("wdog_timeout_flag", to[0], 1);
        check("wdog_err", err_cnt, 1);
        check("wdog_done", done_cnt, 0);
        repeat (3) step(0);
        check("wdog_timeout_sticky", to[0], 1);

        // BERR together with LATCH on beat 1 of a 4-beat burst
        latch_delay[0] = 0;
        berr_beat[0]   = 1;
        run(0, 3, 300, "berr");
        check("berr_latch_count", latch_cnt, 1);
        check("berr_beats_issued", beats_at_as.size(), 2);
        check("berr_last_beat", bt[0], 1);
        check("berr_via_error", (trace.size() >= 2) ? trace[trace.size()-2] : -1, 12);
        check("berr_timeout_flag", to[0], 0);
        check("berr_err", err_cnt, 1);
        check("berr_done", done_cnt, 0);
        berr_beat[0] = -1;

        // Reset while waiting for DSACK on beat 2
        no_latch_beat[0] = 2;
        clear_trk();
        last_s   = int'(st[0]);
        len_v[0] = BW'(3);
        act_v[0] = 1'b1;
        step(0);
        for (int i = 0; i < 300; i++) begin
            if (last_s == 6 && int'(bt[0]) == 2) break;
            step(0);
        end
        check("midrst_reach_state", st[0], 6);
        check("midrst_reach_beat", bt[0], 2);
        rst_a = 1'b0;
        #1;
        check("midrst_state", st[0], 0);
        check("midrst_beat", bt[0], 0);
        check("midrst_busy", by[0], 0);
        check("midrst_done", dn[0], 0);
        check("midrst_err", er[0], 0);
        as_v[0] = 1'b0; latch_v[0] = 1'b0; berr_v[0] = 1'b0;
        no_latch_beat[0] = 99;
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        run(0, 0, 100, "postrst");
        check_walk("postrst");
        check("postrst_done", done_cnt, 1);

        // Four-beat burst with two setup cycles per beat
        run(1, 3, 400, "burst");
        check("burst_latch_count", latch_cnt, 4);
        check("burst_beats_issued", beats_at_as.size(), 4);
        for (int i = 0; i < beats_at_as.size() && i < 4; i++)
            check($sformatf("burst_beat%0d", i), beats_at_as[i], i);
        check("burst_done", done_cnt, 1);
        check("burst_err", err_cnt, 0);
        check("burst_final_beat", bt[1], 3);
        check("burst_das_latency", t_das - t_start, 5);

        // Watchdog disabled: DSACK 5000 cycles late, ACTIVATE hammered while busy
        latch_delay[1] = 5000;
        spam[1]        = 1'b1;
        run(1, 0, 6000, "nowdog");
        spam[1] = 1'b0;
        act_v[1] = 1'b0;
        check("nowdog_long_dwell", (max_dwell >= 5000) ? 1 : 0, 1);
        check("nowdog_no_error", trace.find_first_index(x) with (x == 12).size(), 0);
        check("nowdog_err", err_cnt, 0);
        check("nowdog_done", done_cnt, 1);
        check("nowdog_beats", beats_at_as.size(), 1);
        repeat (5) step(1);
        check("nowdog_idle_state", st[1], 0);
        check("nowdog_no_extra_burst", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_cycle_sequencer.md
# bus_cycle_sequencer

Registered, parametrised bus-cycle state machine for the 68k-side bus engine. It owns the state register and sequences one or more back-to-back transfers per activation. It adds a programmable setup hold, burst beat counting that replaces the external continue flag, and AS/DSACK watchdog timeouts. Bus errors abort the burst and end in a recoverable ERROR state. Its state output drives the existing sequential bus-drive logic.

## Interface
Parameters:
- SETUP_CYCLES, default 1: cycles spent in SETUP_BUS per beat, minimum 1.
- TIMEOUT_CYCLES, default 1024: watchdog limit for DRIVE_AS and WAIT_DSACK. 0 disables the watchdog.
- BEAT_W, default 4: width of the burst length and beat index.
- TMR_W, default 11: timer width. Must satisfy 2^TMR_W > max(TIMEOUT_CYCLES, SETUP_CYCLES).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- ACTIVATE  in  1  start request; sampled only in WAIT.
- BURST_LEN  in  BEAT_W  number of beats minus 1; captured when leaving WAIT.
- AS_FEEDBACK  in  1  synchronised AS level read back from the bus.
- LATCH  in  1  DSACK seen, data ready to latch.
- BERR  in  1  synchronised bus error.
- MC_CLK_RISING  in  1  one-cycle strobe on the 68k clock rising edge.
- STATE  out  4  current state encoding.
- BUSY  out  1  high in every state except WAIT.
- BEAT  out  BEAT_W  index of the current beat, 0-based.
- DONE  out  1  one-cycle pulse when a burst completes without error.
- ERR  out  1  one-cycle pulse when leaving ERROR.
- TIMEOUT  out  1  sticky flag: the last ERROR came from the watchdog, not BERR.

## Operation
State encodings (fixed; checked by the bench):
- WAIT=0, WAKEUP=1, ACTIVATE=2, SETUP_BUS=3, DRIVE_AS=4, DRIVE_DS=5, WAIT_DSACK=6
- LATCH=7, CLEAR_AS=8, ON_DSACK=9, FINALIZE=10, CONTINUE=11, ERROR=12
- Codes 13–15 are illegal and go to WAIT on the next cycle.

Transitions:
- WAIT: if ACTIVATE, go to WAKEUP, capture BURST_LEN into `len_q`, set BEAT=0 and clear TIMEOUT. Otherwise stay.
- WAKEUP goes to ACTIVATE. ACTIVATE goes to SETUP_BUS.
- SETUP_BUS: stay until the timer equals SETUP_CYCLES-1, then go to DRIVE_AS.
- DRIVE_AS, in priority order:
  - AS_FEEDBACK → DRIVE_DS.
  - Watchdog expiry → ERROR, with TIMEOUT set.
  - Otherwise stay.
- DRIVE_DS goes to WAIT_DSACK.
- WAIT_DSACK, in priority order:
  - BERR → ERROR.
  - LATCH → LATCH.
  - Watchdog expiry → ERROR, with TIMEOUT set.
  - Otherwise stay.
- LATCH goes to CLEAR_AS. CLEAR_AS goes to ON_DSACK.
- ON_DSACK: go to FINALIZE when !AS_FEEDBACK && MC_CLK_RISING. Otherwise stay.
- FINALIZE:
  - If BEAT != `len_q`, go to CONTINUE.
  - Otherwise go to WAIT and pulse DONE.
- CONTINUE: go to SETUP_BUS and increment BEAT.
- ERROR: go to WAIT when !AS_FEEDBACK && MC_CLK_RISING, and pulse ERR. Remaining beats are discarded.

Timer:
- Clears on every state change and increments while the state is held. It saturates and does not wrap.
- Watchdog expiry means the timer equals TIMEOUT_CYCLES-1 while TIMEOUT_CYCLES != 0.

Counter and flag rules:
- BEAT is unsigned, BEAT_W bits. With BURST_LEN = 2^BEAT_W-1 the burst runs the full 2^BEAT_W beats, and BEAT never wraps within a burst.
- TIMEOUT holds its value until the next ACTIVATE is accepted.

## Timing
Reset values (asynchronous, while nRESET low):
- STATE=WAIT, BEAT=0, DONE=0, ERR=0, TIMEOUT=0, BUSY=0.
- Internal timer=0, `len_q`=0.
- Reset asserted mid-burst returns to WAIT immediately, with no DONE or ERR pulse.

Output timing:
- All outputs are registered or decoded from registered state; no input-to-output combinational paths.
- DONE and ERR are each high for exactly the one cycle in which STATE reads WAIT after FINALIZE or ERROR respectively.

Latency (ACTIVATE high in WAIT at edge 0):
- STATE=WAKEUP after edge 0.
- SETUP_BUS after edge 2.
- DRIVE_AS after edge 2+SETUP_CYCLES.
- With AS_FEEDBACK already high, DRIVE_DS one edge later, then WAIT_DSACK one edge after that.
- LATCH high in WAIT_DSACK moves to LATCH on the next edge.
- Minimum single beat is WAIT → WAIT in SETUP_CYCLES+9 edges, with every wait condition true on first sample.
- Each extra beat costs SETUP_CYCLES+8 edges, starting from CONTINUE.

Input handling:
- ACTIVATE is ignored while BUSY; it is not queued.
- MC_CLK_RISING is only evaluated in ON_DSACK and ERROR.
- BERR and LATCH arriving together take the BERR path.
- LATCH in the same cycle as watchdog expiry takes the LATCH path.

## Test plan
- Single beat: SETUP_CYCLES=1, BURST_LEN=0, AS_FEEDBACK and LATCH answered immediately, MC_CLK_RISING every 4th cycle → STATE walks 0,1,2,3,4,5,6,7,8,9,10,0. DONE pulses once, BEAT stays 0.
- Burst: BURST_LEN=3, SETUP_CYCLES=2 → four passes through LATCH, with BEAT=0,1,2,3 during each respective DRIVE_AS. Single DONE pulse, no ERR.
- DSACK timeout: TIMEOUT_CYCLES=16, LATCH never asserted → ERROR entered exactly 16 cycles after entering WAIT_DSACK. TIMEOUT=1. ERR pulses after AS drops and MC_CLK_RISING; no DONE.
- BERR on beat 1 of BURST_LEN=3, asserted together with LATCH → ERROR, not LATCH. TIMEOUT=0, ERR pulse, beats 2–3 never issued.
- Reset mid-operation: nRESET low while in WAIT_DSACK on beat 2 → STATE=0 and BEAT=0 immediately. After release, a new ACTIVATE runs a clean single beat.
- Watchdog disabled: TIMEOUT_CYCLES=0, LATCH delayed 5000 cycles → stays in WAIT_DSACK with no ERROR, then completes with DONE. ACTIVATE pulses during BUSY produce no extra burst.
